// File: rtl/ocd_monitor_mem.sv
// ocd_monitor_mem
// Debug monitor memory stage for the on-chip debugger. It services debugger
// read/write commands (arriving as jdo + ocimem strobes from the JTAG wrapper)
// against a single-port monitor RAM. The same RAM is exposed to the CPU through
// an Avalon-MM slave so the CPU can execute the debug monitor code.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   jdo[37:0]                  debugger command/data word
//   take_action_ocimem_a       set-address strobe (jdo[35] clears error, jdo[34] starts read)
//   take_no_action_ocimem_a    read-next strobe (address increment + read)
//   take_action_ocimem_b       write strobe (jdo[34:3] -> RAM[MonAReg], then increment)
//   MonDReg                    data returned to the debugger
//   monitor_ready              last debugger command complete
//   monitor_error              sticky access error
//   avs_*                      CPU Avalon-MM slave (2-cycle reads, 0-wait writes)
//
// Words at ROM_BASE and above are write-protected: debugger writes there are
// suppressed and flagged; CPU writes there need avs_debugaccess.
module ocd_monitor_mem #(
  parameter int AW       = 8,
  parameter int ROM_BASE = 192
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  input  logic          avs_debugaccess,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

  localparam logic [AW-1:0] ROM_START = AW'(ROM_BASE);

  state_t        state;
  logic [AW-1:0] mon_a_reg;     // debugger address register (MonAReg)
  logic [31:0]   wr_data;       // debugger write data held for the WR cycle
  logic          cpu_rd_pend;   // CPU read data is on avs_readdata this cycle
  logic [31:0]   ram_q;         // registered RAM read port
  logic [31:0]   mem [0:(1<<AW)-1];

  logic          any_strobe;
  logic          cpu_grant;
  logic          cpu_rd_grant;
  logic          cpu_wr_grant;
  logic          dbg_rom_hit;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;

  // Only jdo[35:2] carry meaning for this stage.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign any_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign dbg_rom_hit = (mon_a_reg >= ROM_START);

  // The debugger owns the RAM port whenever the FSM is busy or a strobe is
  // being accepted; the CPU gets it only in otherwise idle cycles. A granted
  // CPU read is never re-granted in its data cycle.
  assign cpu_grant    = !reset && (state == IDLE) && !any_strobe && !cpu_rd_pend;
  assign cpu_wr_grant = cpu_grant && avs_write;
  assign cpu_rd_grant = cpu_grant && avs_read && !avs_write;

  assign avs_waitrequest = reset || !(cpu_wr_grant || (cpu_rd_pend && avs_read));
  assign avs_readdata    = ram_q;

  // Single RAM port: address/data mux between debugger FSM and CPU.
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = avs_address;
    ram_wdata = avs_writedata;
    ram_be    = avs_byteenable;
    if (state == RD_ADDR) begin
      ram_re   = 1'b1;
      ram_addr = mon_a_reg;
    end else if (state == WR) begin
      ram_we    = !dbg_rom_hit;
      ram_addr  = mon_a_reg;
      ram_wdata = wr_data;
      ram_be    = 4'hF;
    end else if (cpu_rd_grant) begin
      ram_re = 1'b1;
    end else if (cpu_wr_grant) begin
      // Protected region writes without debugaccess are acknowledged but dropped.
      ram_we = (avs_address < ROM_START) || avs_debugaccess;
    end
    // Reset aborts any write that would otherwise land in this cycle.
    if (reset) ram_we = 1'b0;
  end

  // NOTE: the RAM array itself has no reset (it maps onto block RAM and its
  // contents must survive a reset); only the output register is cleared.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (reset)       ram_q <= '0;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  // Debugger command FSM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      wr_data       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cpu_rd_pend   <= 1'b0;
    end else begin
      cpu_rd_pend <= cpu_rd_grant;

      // Strobes while busy are dropped and flagged.
      if (state != IDLE && any_strobe) monitor_error <= 1'b1;

      case (state)
        IDLE: begin
          // Priority ocimem_b > ocimem_a > no_action_a; losers vanish silently.
          if (take_action_ocimem_b) begin
            wr_data       <= jdo[34:3];
            monitor_ready <= 1'b0;
            state         <= WR;
          end else if (take_action_ocimem_a) begin
            mon_a_reg     <= jdo[AW+1:2];
            monitor_ready <= 1'b0;
            if (jdo[35]) monitor_error <= 1'b0;
            if (jdo[34]) state <= RD_ADDR;
          end else if (take_no_action_ocimem_a) begin
            mon_a_reg     <= mon_a_reg + 1'b1;
            monitor_ready <= 1'b0;
            state         <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        WR: begin
          if (dbg_rom_hit) monitor_error <= 1'b1;
          mon_a_reg     <= mon_a_reg + 1'b1;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocd_monitor_mem.sv
// Testbench for ocd_monitor_mem: directed scenarios plus a randomized mix of
// debugger and CPU accesses, checked against a word-array reference model.
// Expected debugger completions and CPU read acknowledges are queued when
// stimulus is issued; a monitor process pops and compares them as the DUT
// presents monitor_ready rising edges and avs read acknowledges.
module tb_ocd_monitor_mem;

  localparam int AW       = 8;
  localparam int ROM_BASE = 192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          take_action_ocimem_a = 1'b0;
  logic          take_no_action_ocimem_a = 1'b0;
  logic          take_action_ocimem_b = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic          avs_debugaccess = 1'b0;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;

  ocd_monitor_mem #(.AW(AW), .ROM_BASE(ROM_BASE)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t dbg_q[$];
  exp_t cpu_q[$];

  // Reference model: what the RAM and debugger registers should hold.
  logic [31:0] model_mem [256];
  logic [7:0]  model_a    = '0;
  logic        model_err  = 1'b0;
  logic [31:0] model_dreg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare DUT responses against queued expectations.
  initial begin
    exp_t e;
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (monitor_ready && !prev_ready) begin
          if (dbg_q.size() == 0) begin
            check("dbg_unexpected_ready", 32'(dbg_q.size()), 32'd1);
          end else begin
            e = dbg_q.pop_front();
            check("dbg_ready_cycle", cyc, e.cyc);
            check("dbg_MonDReg", MonDReg, e.data);
            check("dbg_error", 32'(monitor_error), 32'(e.err));
          end
        end
        if (avs_read && !avs_waitrequest) begin
          if (cpu_q.size() == 0) begin
            check("cpu_unexpected_ack", 32'(cpu_q.size()), 32'd1);
          end else begin
            e = cpu_q.pop_front();
            check("cpu_ack_cycle", cyc, e.cyc);
            check("cpu_readdata", avs_readdata, e.data);
          end
        end
      end
      prev_ready = monitor_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j       = '0;
    j[35]   = clr;
    j[34]   = rd;
    j[9:2]  = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    tick();
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_dbg();
    int n;
    n = 0;
    while (dbg_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("dbg_done", 32'(dbg_q.size()), 32'd0);
    dbg_q.delete();
    tick();
  endtask

  task automatic dbg_read(input logic [7:0] addr, input logic clr);
    model_a = addr;
    if (clr) model_err = 1'b0;
    model_dreg = model_mem[addr];
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: cyc + 3});
    strobe(1'b1, 1'b0, 1'b0, jdo_a(clr, 1'b1, addr));
    wait_dbg();
  endtask

  task automatic dbg_set(input logic [7:0] addr, input logic clr);
    model_a = addr;
    if (clr) model_err = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(clr, 1'b0, addr));
    check("set_error", 32'(monitor_error), 32'(model_err));
    check("set_ready_cleared", 32'(monitor_ready), 32'd0);
    tick();
  endtask

  task automatic dbg_next();
    model_a    = model_a + 8'd1;
    model_dreg = model_mem[model_a];
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: cyc + 3});
    strobe(1'b0, 1'b1, 1'b0, '0);
    wait_dbg();
  endtask

  task automatic dbg_write(input logic [31:0] data);
    if (int'(model_a) >= ROM_BASE) model_err = 1'b1;
    else model_mem[model_a] = data;
    model_a = model_a + 8'd1;
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: cyc + 2});
    strobe(1'b0, 1'b0, 1'b1, jdo_b(data));
    wait_dbg();
  endtask

  task automatic cpu_read(input logic [7:0] addr);
    int n;
    cpu_q.push_back('{data: model_mem[addr], err: 1'b0, cyc: cyc + 1});
    avs_address = addr;
    avs_read    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 20);
    tick();
    avs_read = 1'b0;
    check("cpu_rd_done", 32'(cpu_q.size()), 32'd0);
    cpu_q.delete();
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic dbg);
    avs_address     = addr;
    avs_writedata   = data;
    avs_byteenable  = be;
    avs_debugaccess = dbg;
    avs_write       = 1'b1;
    @(negedge clk);
    check("cpu_wr_ack", 32'(avs_waitrequest), 32'd0);
    if (int'(addr) < ROM_BASE || dbg) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[addr][8*i +: 8] = data[8*i +: 8];
    end
    tick();
    avs_write       = 1'b0;
    avs_debugaccess = 1'b0;
  endtask

  initial begin
    logic [31:0]  d;
    int unsigned  k;
    int           n;

    // Reset state, with a CPU read pending to observe waitrequest.
    avs_read = 1'b1;
    repeat (3) tick();
    check("rst_MonDReg", MonDReg, 32'd0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    reset    = 1'b0;
    avs_read = 1'b0;
    tick();
    check("idle_waitrequest", 32'(avs_waitrequest), 32'd1);

    // Preload the whole RAM through the CPU port.
    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF, 1'b1);

    // Read of a known word: ready 2 cycles after the strobe.
    cpu_write(8'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    dbg_read(8'd5, 1'b0);

    // Protected-region write at 0xFF: suppressed, error set, address wraps.
    dbg_set(8'hFF, 1'b0);
    dbg_write(32'h12345678);
    cpu_read(8'hFF);
    dbg_next();                 // wrapped address 0 -> reads address 1
    dbg_read(8'd33, 1'b1);      // clears the error

    // Write at 10, then read-next from 9.
    dbg_set(8'd10, 1'b0);
    dbg_write(32'hA5A5A5A5);
    dbg_set(8'd9, 1'b0);
    dbg_next();

    // CPU read collides with a debugger read strobe.
    k = cyc;
    model_a    = 8'd7;
    model_dreg = model_mem[7];
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: k + 3});
    cpu_q.push_back('{data: model_mem[3], err: 1'b0, cyc: k + 4});
    avs_address = 8'd3;
    avs_read    = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'd7));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 20);
    tick();
    avs_read = 1'b0;
    check("cpu_rd_done", 32'(cpu_q.size()), 32'd0);
    cpu_q.delete();
    wait_dbg();

    // CPU write collides with a debugger read of the same word.
    k = cyc;
    model_a    = 8'd44;
    model_dreg = model_mem[44];
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: k + 3});
    avs_address    = 8'd44;
    avs_writedata  = 32'hCAFE0123;
    avs_byteenable = 4'hF;
    avs_write      = 1'b1;
    jdo                  = jdo_a(1'b0, 1'b1, 8'd44);
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    check("cpu_wr_blocked", 32'(avs_waitrequest), 32'd1);
    tick();
    jdo                  = '0;
    take_action_ocimem_a = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 20);
    check("cpu_wr_grant_cycle", cyc, k + 3);
    model_mem[44] = 32'hCAFE0123;
    tick();
    avs_write = 1'b0;
    wait_dbg();
    cpu_read(8'd44);

    // Protected CPU writes with partial byte enables.
    cpu_write(8'd200, 32'h11223344, 4'b0011, 1'b0);
    cpu_read(8'd200);
    cpu_write(8'd200, 32'h11223344, 4'b0011, 1'b1);
    cpu_read(8'd200);
    cpu_write(8'd191, 32'h0BADF00D, 4'b1100, 1'b0);
    cpu_read(8'd191);

    // Reset during RD_ADDR: read aborted, registers cleared.
    dbg_set(8'd250, 1'b0);
    dbg_write($urandom);        // sets the error flag
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'd9));
    reset    = 1'b1;
    avs_read = 1'b1;
    @(negedge clk);
    check("rst_mid_waitrequest", 32'(avs_waitrequest), 32'd1);
    tick();
    reset    = 1'b0;
    avs_read = 1'b0;
    model_a = '0; model_err = 1'b0; model_dreg = '0;
    check("rst_rd_MonDReg", MonDReg, 32'd0);
    check("rst_rd_ready", 32'(monitor_ready), 32'd0);
    check("rst_rd_error", 32'(monitor_error), 32'd0);
    repeat (3) tick();
    check("rst_rd_no_late_ready", 32'(monitor_ready), 32'd0);
    dbg_next();                 // MonAReg back at 0 -> reads address 1

    // Reset during WR: the write must not land.
    dbg_set(8'd20, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, jdo_b(32'h5EED5EED));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_a = '0; model_err = 1'b0; model_dreg = '0;
    tick();
    cpu_read(8'd20);
    dbg_next();

    // Strobe during RD_DATA: dropped, error set, address unchanged.
    model_a    = 8'd40;
    model_dreg = model_mem[40];
    model_err  = 1'b1;
    dbg_q.push_back('{data: model_dreg, err: 1'b1, cyc: cyc + 3});
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'd40));
    tick();
    strobe(1'b0, 1'b1, 1'b0, '0);
    wait_dbg();
    dbg_next();                 // reads 41

    // Strobe during WR (carrying an error-clear bit): dropped, error stays set.
    dbg_set(8'd50, 1'b1);
    d = $urandom;
    model_mem[50] = d;
    model_a   = 8'd51;
    model_err = 1'b1;
    dbg_q.push_back('{data: model_dreg, err: 1'b1, cyc: cyc + 2});
    strobe(1'b0, 1'b0, 1'b1, jdo_b(d));
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b1, 8'd99));
    wait_dbg();
    dbg_next();                 // reads 52
    cpu_read(8'd50);

    // Simultaneous strobes: write beats set-address, no error.
    dbg_set(8'd60, 1'b1);
    d = 32'h0000_0F28;          // jdo[9:2] would point somewhere else
    model_mem[60] = d;
    model_a = 8'd61;
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: cyc + 2});
    strobe(1'b1, 1'b0, 1'b1, jdo_b(d));
    wait_dbg();
    dbg_next();                 // reads 62
    cpu_read(8'd60);

    // Simultaneous strobes: set-address beats read-next.
    model_a    = 8'd70;
    model_dreg = model_mem[70];
    dbg_q.push_back('{data: model_dreg, err: model_err, cyc: cyc + 3});
    strobe(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 1'b1, 8'd70));
    wait_dbg();
    dbg_next();                 // reads 71

    // Randomized mix.
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 5))
        0: dbg_read(8'($urandom), ($urandom_range(0, 3) == 0));
        1: dbg_next();
        2: dbg_write($urandom);
        3: cpu_read(8'($urandom));
        4: cpu_write(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        default: dbg_set(8'($urandom), ($urandom_range(0, 3) == 0));
      endcase
    end

    tick();
    check("final_idle_waitrequest", 32'(avs_waitrequest), 32'd1);
    check("final_dbg_q_empty", 32'(dbg_q.size()), 32'd0);
    check("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
